wavegen_seq: RTL and testbench

//  Synthesizable, programmable multi-channel waveform sequencer. It plays a table of
//  NPH phases; each phase is (duration in clocks, level per channel). It runs
//  one-shot or repeating, and supports start/stop control and a table write port.

---
 rtl/wavegen_seq_if.sv | 32 +++
 rtl/wavegen_seq.sv | 135 +++++++++++++
 tb/tb_wavegen_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wavegen_seq_if.sv
// Control, table-write and waveform signals of the wavegen_seq sequencer.
// The master drives playback control and table writes; the slave (the sequencer)
// drives the waveform and status outputs.
interface wavegen_seq_if #(
   parameter int NCH  = 1,
   parameter int NPH  = 4,
   parameter int CNTW = 8
);
   localparam int AW = (NPH > 1) ? $clog2(NPH) : 1;

   logic            start;
   logic            stop;
   logic            repeat_en;
   logic            cfg_we;
   logic [AW-1:0]   cfg_addr;
   logic [CNTW-1:0] cfg_dur;
   logic [NCH-1:0]  cfg_lvl;
   logic [NCH-1:0]  wave_out;
   logic            busy;
   logic            done;
   logic [AW-1:0]   phase;

   modport master (
      output start, stop, repeat_en, cfg_we, cfg_addr, cfg_dur, cfg_lvl,
      input  wave_out, busy, done, phase
   );

   modport slave (
      input  start, stop, repeat_en, cfg_we, cfg_addr, cfg_dur, cfg_lvl,
      output wave_out, busy, done, phase
   );
endinterface

// File: rtl/wavegen_seq.sv
// Programmable multi-channel waveform sequencer. Plays a table of NPH phases,
// each phase being (duration in clocks, level per channel); the level of a phase
// is driven on wave_out when that phase's duration has elapsed. One-shot or
// repeating playback, stop at any time, table writable only while idle.
module wavegen_seq #(
   parameter int NCH  = 1,
   parameter int NPH  = 4,
   parameter int CNTW = 8
) (
   input  logic          clock,
   input  logic          reset_n,
   wavegen_seq_if.slave  bus
);
   localparam int AW = (NPH > 1) ? $clog2(NPH) : 1;
   localparam logic [AW-1:0] LAST = AW'(NPH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   // Default program restored by reset: dur={12,5,3,10,1,1,...}.
   function automatic logic [CNTW-1:0] def_dur(input int idx);
      case (idx)
         0:       return CNTW'(12);
         1:       return CNTW'(5);
         2:       return CNTW'(3);
         3:       return CNTW'(10);
         default: return CNTW'(1);
      endcase
   endfunction

   // Default levels {0,1,0,1,0,0,...}, identical on every channel.
   function automatic logic [NCH-1:0] def_lvl(input int idx);
      return (idx == 1 || idx == 3) ? {NCH{1'b1}} : '0;
   endfunction

   // Counter load value for a duration: a duration of 0 plays as 1 clock.
   function automatic logic [CNTW-1:0] load_of(input logic [CNTW-1:0] d);
      return (d == '0) ? '0 : d - CNTW'(1);
   endfunction

   state_t          state_q;
   logic [CNTW-1:0] cnt_q;
   logic [AW-1:0]   phase_q;
   logic            rpt_q;
   logic            busy_q;
   logic            done_q;
   logic [NCH-1:0]  wave_q;

   logic [CNTW-1:0] dur_q [NPH];
   logic [NCH-1:0]  lvl_q [NPH];

   logic [AW-1:0]   nxt_idx_d;
   logic [CNTW-1:0] first_load_d;
   logic [CNTW-1:0] next_load_d;

   // Table entries: one register set per phase, written only while idle. An
   // out-of-range address matches no entry, so such writes vanish.
   generate
      for (genvar gi = 0; gi < NPH; gi++) begin : g_tab
         // Reset to the default program; accept an idle write addressed here.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               dur_q[gi] <= def_dur(gi);
               lvl_q[gi] <= def_lvl(gi);
            end else if (bus.cfg_we && state_q == IDLE && bus.cfg_addr == AW'(gi)) begin
               dur_q[gi] <= bus.cfg_dur;
               lvl_q[gi] <= bus.cfg_lvl;
            end
         end
      end
   endgenerate

   // Counter loads: a write to phase 0 in the start cycle is forwarded so the
   // first phase already uses the new duration.
   always_comb begin
      nxt_idx_d    = (phase_q == LAST) ? '0 : phase_q + AW'(1);
      first_load_d = (bus.cfg_we && bus.cfg_addr == '0) ? load_of(bus.cfg_dur)
                                                         : load_of(dur_q[0]);
      next_load_d  = load_of(dur_q[nxt_idx_d]);
   end

   // Playback FSM with registered outputs; stop overrides everything else.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         phase_q <= '0;
         rpt_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wave_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            phase_q <= '0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start) begin
                     state_q <= RUN;
                     phase_q <= '0;
                     cnt_q   <= first_load_d;
                     busy_q  <= 1'b1;
                     rpt_q   <= bus.repeat_en;
                  end
               end
               RUN: begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - CNTW'(1);
                  end else begin
                     wave_q <= lvl_q[phase_q];
                     if (phase_q != LAST || rpt_q) begin
                        phase_q <= nxt_idx_d;
                        cnt_q   <= next_load_d;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        phase_q <= '0;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.wave_out = wave_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.phase    = phase_q;
endmodule

// File: tb/tb_wavegen_seq.sv
// Directed bench for wavegen_seq: a 1-channel/4-phase instance for the main
// scenarios and a 3-channel/6-phase instance for per-channel levels and the
// extra default phases. Times are counted in edges after the start edge T.
module tb_wavegen_seq;
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   errors  = 0;
   int   checks  = 0;
   int   now_e   = 0;

   always #5 clock = ~clock;

   wavegen_seq_if #(.NCH(1), .NPH(4), .CNTW(8)) bus4 ();
   wavegen_seq_if #(.NCH(3), .NPH(6), .CNTW(8)) bus6 ();

   wavegen_seq #(.NCH(1), .NPH(4), .CNTW(8)) u_dut4 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus4)
   );

   wavegen_seq #(.NCH(3), .NPH(6), .CNTW(8)) u_dut6 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus6)
   );

   // Move to 1 time unit after edge T+k.
   task automatic adv_to(input int k);
      if (k > now_e) begin
         repeat (k - now_e) @(posedge clock);
         #1;
         now_e = k;
      end
   endtask

   task automatic clear_inputs();
      bus4.start = 0; bus4.stop = 0; bus4.repeat_en = 0; bus4.cfg_we = 0;
      bus4.cfg_addr = '0; bus4.cfg_dur = '0; bus4.cfg_lvl = '0;
      bus6.start = 0; bus6.stop = 0; bus6.repeat_en = 0; bus6.cfg_we = 0;
      bus6.cfg_addr = '0; bus6.cfg_dur = '0; bus6.cfg_lvl = '0;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset_n = 0;
      clear_inputs();
      @(negedge clock);
      reset_n = 1;
   endtask

   task automatic start4(input logic rpt);
      @(negedge clock);
      bus4.start = 1; bus4.repeat_en = rpt;
      @(posedge clock);
      #1;
      bus4.start = 0;
      now_e = 0;
   endtask

   task automatic write4(input int addr, input int dur, input int lvl);
      @(negedge clock);
      bus4.cfg_we = 1; bus4.cfg_addr = 2'(addr); bus4.cfg_dur = 8'(dur); bus4.cfg_lvl = 1'(lvl);
      @(posedge clock);
      #1;
      bus4.cfg_we = 0;
      now_e++;
   endtask

   task automatic stop4_now();
      bus4.stop = 1;
      adv_to(now_e + 1);
      bus4.stop = 0;
   endtask

   task automatic test_reset();
      $display("test_reset");
      @(negedge clock);
      reset_n = 0;
      clear_inputs();
      #1;
      checks++;
      if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !== 5'b0) begin
         errors++;
         $display("FAIL reset4 in reset: wave=%b busy=%b done=%b phase=%0d, expected all 0",
                  bus4.wave_out, bus4.busy, bus4.done, bus4.phase);
      end
      @(negedge clock);
      reset_n = 1;
      @(negedge clock);
      checks++;
      if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !== 5'b0) begin
         errors++;
         $display("FAIL reset4 after release: wave=%b busy=%b done=%b phase=%0d, expected all 0",
                  bus4.wave_out, bus4.busy, bus4.done, bus4.phase);
      end
      checks++;
      if ({bus6.wave_out, bus6.busy, bus6.done, bus6.phase} !== 8'b0) begin
         errors++;
         $display("FAIL reset6 after release: wave=%b busy=%b done=%b phase=%0d, expected all 0",
                  bus6.wave_out, bus6.busy, bus6.done, bus6.phase);
      end
   endtask

   // Rows: {edge after T, wave, busy, done, phase}
   task automatic test_repeat();
      int tab [11][5] = '{'{11,0,1,0,0}, '{12,0,1,0,1}, '{16,0,1,0,1}, '{17,1,1,0,2},
                          '{19,1,1,0,2}, '{20,0,1,0,3}, '{29,0,1,0,3}, '{30,1,1,0,0},
                          '{41,1,1,0,0}, '{42,0,1,0,1}, '{47,1,1,0,2}};
      $display("test_repeat");
      apply_reset();
      start4(1);
      for (int i = 0; i < 11; i++) begin
         adv_to(tab[i][0]);
         checks++;
         if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !==
             {1'(tab[i][1]), 1'(tab[i][2]), 1'(tab[i][3]), 2'(tab[i][4])}) begin
            errors++;
            $display("FAIL repeat T+%0d: wave=%b busy=%b done=%b phase=%0d, expected %0d %0d %0d %0d",
                     tab[i][0], bus4.wave_out, bus4.busy, bus4.done, bus4.phase,
                     tab[i][1], tab[i][2], tab[i][3], tab[i][4]);
         end
      end
      stop4_now();
      checks++;
      if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !== 5'b10000) begin
         errors++;
         $display("FAIL repeat_stop: wave=%b busy=%b done=%b phase=%0d, expected 1 0 0 0",
                  bus4.wave_out, bus4.busy, bus4.done, bus4.phase);
      end
   endtask

   task automatic test_one_shot();
      int tab [4][5] = '{'{29,0,1,0,3}, '{30,1,0,1,0}, '{31,1,0,0,0}, '{35,1,0,0,0}};
      $display("test_one_shot");
      apply_reset();
      start4(0);
      for (int i = 0; i < 4; i++) begin
         adv_to(tab[i][0]);
         checks++;
         if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !==
             {1'(tab[i][1]), 1'(tab[i][2]), 1'(tab[i][3]), 2'(tab[i][4])}) begin
            errors++;
            $display("FAIL one_shot T+%0d: wave=%b busy=%b done=%b phase=%0d, expected %0d %0d %0d %0d",
                     tab[i][0], bus4.wave_out, bus4.busy, bus4.done, bus4.phase,
                     tab[i][1], tab[i][2], tab[i][3], tab[i][4]);
         end
      end
   endtask

   task automatic test_program();
      int tab [7][5] = '{'{0,0,1,0,0}, '{1,1,1,0,1}, '{2,0,1,0,2}, '{3,0,1,0,2},
                         '{4,1,1,0,3}, '{5,0,0,1,0}, '{6,0,0,0,0}};
      $display("test_program");
      apply_reset();
      write4(0, 1, 1);
      write4(1, 0, 0);
      write4(2, 2, 1);
      write4(3, 1, 0);
      start4(0);
      for (int i = 0; i < 7; i++) begin
         adv_to(tab[i][0]);
         checks++;
         if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !==
             {1'(tab[i][1]), 1'(tab[i][2]), 1'(tab[i][3]), 2'(tab[i][4])}) begin
            errors++;
            $display("FAIL program T+%0d: wave=%b busy=%b done=%b phase=%0d, expected %0d %0d %0d %0d",
                     tab[i][0], bus4.wave_out, bus4.busy, bus4.done, bus4.phase,
                     tab[i][1], tab[i][2], tab[i][3], tab[i][4]);
         end
      end
   endtask

   task automatic test_stop();
      $display("test_stop");
      apply_reset();
      start4(1);
      adv_to(14);
      stop4_now();
      checks++;
      if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !== 5'b00000) begin
         errors++;
         $display("FAIL stop_at_15: wave=%b busy=%b done=%b phase=%0d, expected 0 0 0 0",
                  bus4.wave_out, bus4.busy, bus4.done, bus4.phase);
      end
      // stop and start together: stop wins
      @(negedge clock);
      bus4.start = 1; bus4.stop = 1; bus4.repeat_en = 1;
      @(posedge clock);
      #1;
      bus4.start = 0; bus4.stop = 0;
      checks++;
      if (bus4.busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_beats_start: busy=%b, expected 0", bus4.busy);
      end
      // restart plays from phase 0 again
      start4(1);
      adv_to(11);
      checks++;
      if (bus4.phase !== 2'd0) begin
         errors++;
         $display("FAIL restart T+11: phase=%0d, expected 0", bus4.phase);
      end
      adv_to(12);
      checks++;
      if ({bus4.busy, bus4.phase} !== 3'b101) begin
         errors++;
         $display("FAIL restart T+12: busy=%b phase=%0d, expected 1 1", bus4.busy, bus4.phase);
      end
      // stop in the same cycle as a level update: level must not change
      adv_to(16);
      stop4_now();
      checks++;
      if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !== 5'b00000) begin
         errors++;
         $display("FAIL stop_beats_update T+17: wave=%b busy=%b done=%b phase=%0d, expected 0 0 0 0",
                  bus4.wave_out, bus4.busy, bus4.done, bus4.phase);
      end
   endtask

   task automatic test_start_ignored();
      $display("test_start_ignored");
      apply_reset();
      start4(1);
      adv_to(4);
      bus4.start = 1;
      adv_to(5);
      bus4.start = 0;
      adv_to(12);
      checks++;
      if (bus4.phase !== 2'd1) begin
         errors++;
         $display("FAIL start_in_run T+12: phase=%0d, expected 1", bus4.phase);
      end
      adv_to(17);
      checks++;
      if ({bus4.wave_out, bus4.phase} !== 3'b110) begin
         errors++;
         $display("FAIL start_in_run T+17: wave=%b phase=%0d, expected 1 2", bus4.wave_out, bus4.phase);
      end
      stop4_now();
   endtask

   task automatic test_cfg_busy();
      int tab [6][5] = '{'{1,0,1,0,0}, '{2,0,1,0,1}, '{6,0,1,0,1}, '{7,1,1,0,2},
                         '{10,0,1,0,3}, '{20,1,0,1,0}};
      $display("test_cfg_busy");
      apply_reset();
      start4(1);
      adv_to(2);
      bus4.cfg_we = 1; bus4.cfg_addr = 2'd0; bus4.cfg_dur = 8'd2; bus4.cfg_lvl = 1'b1;
      adv_to(3);
      bus4.cfg_we = 0;
      adv_to(30);
      checks++;
      if ({bus4.wave_out, bus4.phase} !== 3'b100) begin
         errors++;
         $display("FAIL busy_write T+30: wave=%b phase=%0d, expected 1 0", bus4.wave_out, bus4.phase);
      end
      adv_to(41);
      checks++;
      if ({bus4.wave_out, bus4.phase} !== 3'b100) begin
         errors++;
         $display("FAIL busy_write T+41: wave=%b phase=%0d, expected 1 0", bus4.wave_out, bus4.phase);
      end
      adv_to(42);
      checks++;
      if ({bus4.wave_out, bus4.phase} !== 3'b001) begin
         errors++;
         $display("FAIL busy_write T+42: wave=%b phase=%0d, expected 0 1", bus4.wave_out, bus4.phase);
      end
      stop4_now();
      // write phase 0 and start in the same idle cycle
      @(negedge clock);
      bus4.cfg_we = 1; bus4.cfg_addr = 2'd0; bus4.cfg_dur = 8'd2; bus4.cfg_lvl = 1'b0;
      bus4.start = 1; bus4.repeat_en = 0;
      @(posedge clock);
      #1;
      bus4.cfg_we = 0; bus4.start = 0;
      now_e = 0;
      for (int i = 0; i < 6; i++) begin
         adv_to(tab[i][0]);
         checks++;
         if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !==
             {1'(tab[i][1]), 1'(tab[i][2]), 1'(tab[i][3]), 2'(tab[i][4])}) begin
            errors++;
            $display("FAIL write_and_start T+%0d: wave=%b busy=%b done=%b phase=%0d, expected %0d %0d %0d %0d",
                     tab[i][0], bus4.wave_out, bus4.busy, bus4.done, bus4.phase,
                     tab[i][1], tab[i][2], tab[i][3], tab[i][4]);
         end
      end
   endtask

   task automatic test_async_reset();
      $display("test_async_reset");
      apply_reset();
      write4(0, 2, 1);
      start4(1);
      adv_to(8);
      checks++;
      if ({bus4.wave_out, bus4.busy, bus4.phase} !== 4'b1110) begin
         errors++;
         $display("FAIL pre_reset T+8: wave=%b busy=%b phase=%0d, expected 1 1 2",
                  bus4.wave_out, bus4.busy, bus4.phase);
      end
      #2;
      reset_n = 0;
      #1;
      checks++;
      if ({bus4.wave_out, bus4.busy, bus4.done, bus4.phase} !== 5'b0) begin
         errors++;
         $display("FAIL async_reset: wave=%b busy=%b done=%b phase=%0d, expected all 0",
                  bus4.wave_out, bus4.busy, bus4.done, bus4.phase);
      end
      @(negedge clock);
      reset_n = 1;
      start4(1);
      adv_to(11);
      checks++;
      if ({bus4.wave_out, bus4.phase} !== 3'b000) begin
         errors++;
         $display("FAIL replay T+11: wave=%b phase=%0d, expected 0 0", bus4.wave_out, bus4.phase);
      end
      adv_to(12);
      checks++;
      if ({bus4.wave_out, bus4.phase} !== 3'b001) begin
         errors++;
         $display("FAIL replay T+12: wave=%b phase=%0d, expected 0 1", bus4.wave_out, bus4.phase);
      end
      adv_to(17);
      checks++;
      if ({bus4.wave_out, bus4.phase} !== 3'b110) begin
         errors++;
         $display("FAIL replay T+17: wave=%b phase=%0d, expected 1 2", bus4.wave_out, bus4.phase);
      end
      stop4_now();
   endtask

   task automatic test_multi_channel();
      int tab [9][5] = '{'{2,5,1,0,1}, '{6,5,1,0,1}, '{7,2,1,0,2}, '{10,0,1,0,3},
                         '{19,0,1,0,3}, '{20,7,1,0,4}, '{21,0,1,0,5}, '{22,0,0,1,0},
                         '{23,0,0,0,0}};
      int wr [3][3] = '{'{0,2,5}, '{1,5,2}, '{7,50,7}};
      $display("test_multi_channel");
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         bus6.cfg_we = 1; bus6.cfg_addr = 3'(wr[i][0]); bus6.cfg_dur = 8'(wr[i][1]);
         bus6.cfg_lvl = 3'(wr[i][2]);
         @(posedge clock);
         #1;
         bus6.cfg_we = 0;
      end
      @(negedge clock);
      bus6.start = 1; bus6.repeat_en = 0;
      @(posedge clock);
      #1;
      bus6.start = 0;
      now_e = 0;
      for (int i = 0; i < 9; i++) begin
         adv_to(tab[i][0]);
         checks++;
         if ({bus6.wave_out, bus6.busy, bus6.done, bus6.phase} !==
             {3'(tab[i][1]), 1'(tab[i][2]), 1'(tab[i][3]), 3'(tab[i][4])}) begin
            errors++;
            $display("FAIL multi_ch T+%0d: wave=%b busy=%b done=%b phase=%0d, expected %03b %0d %0d %0d",
                     tab[i][0], bus6.wave_out, bus6.busy, bus6.done, bus6.phase,
                     3'(tab[i][1]), tab[i][2], tab[i][3], tab[i][4]);
         end
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_repeat();
      test_one_shot();
      test_program();
      test_stop();
      test_start_ignored();
      test_cfg_busy();
      test_async_reset();
      test_multi_channel();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
